// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame-length width and the
// word-length clamp used when a frame starts.
package uart_pkg;

    localparam int unsigned BITS_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4,
        ST_DONE  = 3'd5
    } uart_state_t;

    // Zero or oversize lengths fall back to the full word.
    function automatic logic [BITS_W-1:0] clamp_bits(input logic [BITS_W-1:0] bits,
                                                     input int unsigned max_bits);
        if (bits == '0 || 32'(bits) > max_bits) begin
            return BITS_W'(max_bits);
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and word length in, word and status out.
interface uart_rx_if import uart_pkg::*; #(
    parameter int unsigned MAX_WORD_SIZE = 8
);
    logic                     rx;
    logic [BITS_W-1:0]        rx_bits;
    logic [MAX_WORD_SIZE-1:0] dout;
    logic                     rx_done;
    logic                     frame_err;
    logic                     rx_busy;

    modport master (output rx, rx_bits, input dout, rx_done, frame_err, rx_busy);
    modport slave  (input rx, rx_bits, output dout, rx_done, frame_err, rx_busy);
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for asynchronous lines that idle high.
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing with mid-bit sampling, break
// handling and one-cycle done / framing-error strobes.
module uart_rx import uart_pkg::*; #(
    parameter int unsigned MAX_WORD_SIZE = 8,
    parameter int unsigned CLKS_PER_BIT  = 1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_rx_if.slave    bus
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_s)
    );

    uart_state_t              state, state_nx;
    logic [CNT_W-1:0]         cnt, cnt_nx;
    logic [BITS_W-1:0]        idx, idx_nx;
    logic [BITS_W-1:0]        nbits, nbits_nx;
    logic [MAX_WORD_SIZE-1:0] shreg, shreg_nx;
    logic [MAX_WORD_SIZE-1:0] dout, dout_nx;
    logic                     rx_done, rx_done_nx;
    logic                     frame_err, frame_err_nx;
    logic                     rx_busy, rx_busy_nx;
    logic                     sample_pt;
    logic                     last_bit;

    assign sample_pt = (cnt == SAMPLE_CNT);
    assign last_bit  = (idx == nbits - BITS_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // With one clk per bit the detection cycle doubles as the start sample.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (!rx_s)     state_nx = (CLKS_PER_BIT == 1) ? ST_DATA : ST_START;
            ST_START: if (sample_pt) state_nx = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (sample_pt && last_bit) state_nx = ST_STOP;
            ST_STOP:  if (sample_pt) state_nx = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s)      state_nx = ST_IDLE;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_nx       = (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
        idx_nx       = idx;
        nbits_nx     = nbits;
        shreg_nx     = shreg;
        dout_nx      = dout;
        rx_done_nx   = 1'b0;
        frame_err_nx = 1'b0;
        rx_busy_nx   = (state_nx != ST_IDLE);
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                idx_nx = '0;
                if (!rx_s) begin
                    nbits_nx = clamp_bits(bus.rx_bits, MAX_WORD_SIZE);
                    shreg_nx = '0;
                end
            end
            ST_DATA: begin
                if (sample_pt) begin
                    shreg_nx = shreg | (MAX_WORD_SIZE'(rx_s) << idx);
                    idx_nx   = idx + BITS_W'(1);
                end
            end
            ST_STOP: begin
                if (sample_pt) begin
                    if (rx_s) begin
                        dout_nx    = shreg;
                        rx_done_nx = 1'b1;
                    end else begin
                        frame_err_nx = 1'b1;
                    end
                end
            end
            ST_BREAK: cnt_nx = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            nbits     <= '0;
            shreg     <= '0;
            dout      <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            nbits     <= nbits_nx;
            shreg     <= shreg_nx;
            dout      <= dout_nx;
            rx_done   <= rx_done_nx;
            frame_err <= frame_err_nx;
            rx_busy   <= rx_busy_nx;
        end
    end

    assign bus.dout      = dout;
    assign bus.rx_done   = rx_done;
    assign bus.frame_err = frame_err;
    assign bus.rx_busy   = rx_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one receiver at one clk per bit, one at four clks per bit,
// fed with bit-banged frames and scored against a frame-level expectation queue.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if #(.MAX_WORD_SIZE(W)) bus1 ();
    uart_rx_if #(.MAX_WORD_SIZE(W)) bus4 ();

    uart_rx #(.MAX_WORD_SIZE(W), .CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    uart_rx #(.MAX_WORD_SIZE(W), .CLKS_PER_BIT(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic         ferr;
        logic [W-1:0] word;
    } exp_t;

    exp_t        exp1[$];
    exp_t        exp4[$];
    int unsigned stop_t1[$];
    exp_t        e1, e4;
    int          n_checks = 0, n_errors = 0;
    int          n_done1 = 0, n_ferr1 = 0, n_done4 = 0, n_ferr4 = 0;
    int          exp_done1 = 0, exp_ferr1 = 0, exp_done4 = 0, exp_ferr4 = 0;
    logic [W-1:0] prev_dout1, prev_dout4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: a frame carries min-clamped length bits of data, LSB first.
    function automatic int frame_len(input logic [BITS_W-1:0] rb);
        if (rb == 0 || int'(rb) > int'(W)) return int'(W);
        return int'(rb);
    endfunction

    function automatic logic [W-1:0] expected_word(input logic [W-1:0] data, input int n);
        return W'(32'(data) & ((32'd1 << n) - 32'd1));
    endfunction

    always @(negedge clk) begin
        if (bus1.rx_done || bus1.frame_err) begin
            check("rx1_excl", 32'(bus1.rx_done & bus1.frame_err), 0);
            if (exp1.size() == 0) begin
                check("rx1_unexpected_pulse", 1, 0);
            end else begin
                e1 = exp1.pop_front();
                check("rx1_kind", 32'(bus1.frame_err), 32'(e1.ferr));
                if (bus1.rx_done) check("rx1_dout", 32'(bus1.dout), 32'(e1.word));
                else              check("rx1_dout_hold", 32'(bus1.dout), 32'(prev_dout1));
                check("rx1_latency", cyc - stop_t1.pop_front(), 3);
            end
            if (bus1.rx_done) n_done1++; else n_ferr1++;
        end
        prev_dout1 = bus1.dout;
    end

    always @(negedge clk) begin
        if (bus4.rx_done || bus4.frame_err) begin
            check("rx4_excl", 32'(bus4.rx_done & bus4.frame_err), 0);
            if (exp4.size() == 0) begin
                check("rx4_unexpected_pulse", 1, 0);
            end else begin
                e4 = exp4.pop_front();
                check("rx4_kind", 32'(bus4.frame_err), 32'(e4.ferr));
                if (bus4.rx_done) check("rx4_dout", 32'(bus4.dout), 32'(e4.word));
                else              check("rx4_dout_hold", 32'(bus4.dout), 32'(prev_dout4));
            end
            if (bus4.rx_done) n_done4++; else n_ferr4++;
        end
        prev_dout4 = bus4.dout;
    end

    task automatic send_frame1(input logic [W-1:0] data, input logic [BITS_W-1:0] rb,
                               input logic stop_bit, input int gap);
        int   n = frame_len(rb);
        exp_t e;
        @(negedge clk);
        bus1.rx_bits = rb;
        bus1.rx      = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus1.rx = data[i];
        end
        @(negedge clk);
        bus1.rx = stop_bit;
        e.ferr = ~stop_bit;
        e.word = expected_word(data, n);
        exp1.push_back(e);
        stop_t1.push_back(cyc);
        if (stop_bit) exp_done1++; else exp_ferr1++;
        repeat (gap) begin
            @(negedge clk);
            bus1.rx = 1'b1;
        end
    endtask

    // Each internal bit edge may land one clk early or late.
    task automatic send_frame4(input logic [W-1:0] data, input logic [BITS_W-1:0] rb,
                               input logic stop_bit, input int gap, input bit jitter);
        int   n = frame_len(rb);
        logic bits[$];
        int   e_prev = 0;
        int   e_next;
        int   dur;
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) bits.push_back(data[i]);
        bits.push_back(stop_bit);
        for (int i = 0; i < bits.size(); i++) begin
            e_next = (jitter && (i + 1) < bits.size()) ? int'($urandom_range(2, 0)) - 1 : 0;
            dur    = 4 + e_next - e_prev;
            @(negedge clk);
            if (i == 0) bus4.rx_bits = rb;
            bus4.rx = bits[i];
            if (i == bits.size() - 1) begin
                e.ferr = ~stop_bit;
                e.word = expected_word(data, n);
                exp4.push_back(e);
                if (stop_bit) exp_done4++; else exp_ferr4++;
            end
            repeat (dur - 1) @(negedge clk);
            e_prev = e_next;
        end
        repeat (gap) begin
            @(negedge clk);
            bus4.rx = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [W-1:0]      rd;
    logic [BITS_W-1:0] rbits;
    logic              bad;
    logic [W-1:0]      dout_before;
    int                done_before;
    int                len;
    bit                seen;

    initial begin
        bus1.rx = 1'b1; bus1.rx_bits = BITS_W'(8);
        bus4.rx = 1'b1; bus4.rx_bits = BITS_W'(8);
        rst_n = 1'b0;
        idle(3);
        check("rst_dout1", 32'(bus1.dout), 0);
        check("rst_done1", 32'(bus1.rx_done), 0);
        check("rst_ferr1", 32'(bus1.frame_err), 0);
        check("rst_busy1", 32'(bus1.rx_busy), 0);
        check("rst_dout4", 32'(bus4.dout), 0);
        check("rst_busy4", 32'(bus4.rx_busy), 0);
        rst_n = 1'b1;
        idle(4);

        // One clk per bit: directed, back-to-back short words, clamp, random.
        send_frame1(8'hA5, BITS_W'(8), 1'b1, 2);
        send_frame1(8'hFF, BITS_W'(5), 1'b1, 2);
        send_frame1(8'h13, BITS_W'(5), 1'b1, 0);
        send_frame1(8'h6B, BITS_W'(63), 1'b1, 0);
        send_frame1(8'hC9, BITS_W'(0), 1'b1, 1);
        for (int i = 0; i < 40; i++) begin
            rd    = W'($urandom);
            rbits = BITS_W'($urandom_range(12, 0));
            bad   = ($urandom_range(7, 0) == 0);
            send_frame1(rd, rbits, ~bad, bad ? int'($urandom_range(3, 1)) : int'($urandom_range(3, 0)));
        end
        idle(10);

        // Four clks per bit with edge jitter.
        for (int i = 0; i < 6; i++) send_frame4(8'h3C, BITS_W'(8), 1'b1, 2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            rd    = W'($urandom);
            rbits = BITS_W'($urandom_range(10, 1));
            send_frame4(rd, rbits, 1'b1, int'($urandom_range(5, 0)), 1'b1);
        end
        idle(12);

        // Single-clk glitch on an idle line.
        dout_before = bus4.dout;
        done_before = n_done4;
        @(negedge clk); bus4.rx = 1'b0;
        @(negedge clk); bus4.rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus4.rx_busy) seen = 1'b1; else @(negedge clk);
        end
        check("glitch_busy_rose", 32'(seen), 1);
        len = 0;
        while (bus4.rx_busy && len < 10) begin
            len++;
            @(negedge clk);
        end
        check("glitch_busy_short", 32'(len <= 3), 1);
        idle(20);
        check("glitch_no_done", 32'(n_done4), 32'(done_before));
        check("glitch_dout_kept", 32'(bus4.dout), 32'(dout_before));

        // Bad stop bit followed by a held-low line.
        send_frame4(8'h55, BITS_W'(8), 1'b0, 0, 1'b0);
        repeat (20) begin
            @(negedge clk);
            bus4.rx = 1'b0;
        end
        check("break_busy_held", 32'(bus4.rx_busy), 1);
        check("break_one_ferr", 32'(n_ferr4), 32'(exp_ferr4));
        @(negedge clk); bus4.rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (!bus4.rx_busy) seen = 1'b1; else @(negedge clk);
        end
        check("break_busy_released", 32'(seen), 1);
        send_frame4(8'h0F, BITS_W'(8), 1'b1, 4, 1'b0);
        idle(12);
        check("after_break_dout", 32'(bus4.dout), 32'h0F);

        // Reset during data bit 3 of 8'hC3 aborts the frame.
        @(negedge clk); bus1.rx_bits = BITS_W'(8); bus1.rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus1.rx = rd[0] | 1'b1 ? (i < 2) : 1'b0;
        end
        @(negedge clk); bus1.rx = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midrst_dout", 32'(bus1.dout), 0);
        check("midrst_done", 32'(bus1.rx_done), 0);
        check("midrst_ferr", 32'(bus1.frame_err), 0);
        check("midrst_busy", 32'(bus1.rx_busy), 0);
        rst_n = 1'b1; bus1.rx = 1'b1;
        idle(24);
        check("midrst_no_pulse", 32'(n_done1 + n_ferr1), 32'(exp_done1 + exp_ferr1));
        send_frame1(8'h81, BITS_W'(8), 1'b1, 2);
        idle(10);
        check("after_rst_dout", 32'(bus1.dout), 32'h81);

        idle(10);
        check("rx1_done_count", 32'(n_done1), 32'(exp_done1));
        check("rx1_ferr_count", 32'(n_ferr1), 32'(exp_ferr1));
        check("rx1_pending", 32'(exp1.size()), 0);
        check("rx4_done_count", 32'(n_done4), 32'(exp_done4));
        check("rx4_ferr_count", 32'(n_ferr4), 32'(exp_ferr4));
        check("rx4_pending", 32'(exp4.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
